// File: rtl/bin_to_bcd_seq_if.sv
// Start/done handshake and result bus for the sequential binary-to-BCD converter.
// The master drives requests and the converter (slave) returns the packed digits.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf;

  modport master (output start, bin_in, input busy, done, bcd_out, ovf);
  modport slave  (input start, bin_in, output busy, done, bcd_out, ovf);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 (double-dabble) binary-to-BCD converter, one iteration per clock.
// Optional macro XS3_OUT_EN: result digits are emitted in excess-3 code instead of plain BCD.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  bin_to_bcd_seq_if.slave  io_bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          CNT_W   = $clog2(BIN_W) + 1;
  localparam int unsigned MAX_VAL = 10**DIGITS - 1;

  logic [1:0]       r_state;
  logic [BIN_W-1:0] r_shift;
  logic [BCD_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovfNext;
  logic [BCD_W-1:0] r_bcd;
  logic             r_ovf;
  logic             r_done;
  logic             r_busy;

  logic [BCD_W-1:0] w_adjAcc;
  logic [BCD_W-1:0] w_finalBcd;
  logic             w_ovfCmp;

  assign w_ovfCmp = {{(32-BIN_W){1'b0}}, io_bus.bin_in} > MAX_VAL;

  // Digits of five or more get +3 so the following left shift carries correctly into the next digit.
  always_comb begin
    w_adjAcc = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5)
        w_adjAcc[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      else
        w_adjAcc[4*d +: 4] = r_acc[4*d +: 4];
    end
  end

`ifdef XS3_OUT_EN
  always_comb begin
    w_finalBcd = '0;
    for (int d = 0; d < DIGITS; d++)
      w_finalBcd[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
  end
`else
  assign w_finalBcd = r_acc;
`endif

  // A start arriving while done is high is dropped, so a new request only lands one cycle after the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovfNext <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_bus.start && !r_done) begin
            r_shift   <= io_bus.bin_in;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovfNext <= w_ovfCmp;
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_acc   <= {w_adjAcc[BCD_W-2:0], r_shift[BIN_W-1]};
          r_shift <= {r_shift[BIN_W-2:0], 1'b0};
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(BIN_W - 1))
            r_state <= S_DONE;
        end
        S_DONE: begin
          r_bcd   <= w_finalBcd;
          r_ovf   <= r_ovfNext;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.busy    = r_busy;
  assign io_bus.done    = r_done;
  assign io_bus.bcd_out = r_bcd;
  assign io_bus.ovf     = r_ovf;

endmodule
